// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with a retired-instruction counter.
// Build option MEM_WAIT_EN: FETCH and MEM wait for mem_ready; otherwise they complete in one cycle.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [15:0] instret_q, instret_d;
  logic        mem_done;
  logic        retire;
  logic        op_legal;

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opcode_d = opcode;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      // From here on only the latched opcode steers the instruction.
      S_EXEC: begin
        case (opcode_q)
          OP_R, OP_I:        state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            PCWrite = branch_cond;
            PCSrc   = branch_cond ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JAL: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            state_d = S_WB;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (opcode_q == OP_STORE) begin
          MemWrite = 1'b1;
          if (mem_done) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          MemRead = 1'b1;
          if (mem_done) state_d = S_WB;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    instret_d = instret_q + {15'd0, retire};

    // Reset silences every strobe in the cycle it is asserted.
    if (reset) begin
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= 7'd0;
      instret_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer: per-cycle expected outputs queued as stimulus is driven, compared mid-cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        branch_cond;
  logic        mem_ready;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        IRWrite, MemRead, MemWrite, RegWrite;
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] instret;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .state(state),
    .illegal(illegal), .instret(instret)
  );

  // {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, illegal}
  typedef logic [10:0] obs_t;
  localparam obs_t F_DONE  = 11'b000_1_00_1_1_0_0_0;
  localparam obs_t F_WAIT  = 11'b000_0_00_0_1_0_0_0;
  localparam obs_t DEC     = 11'b001_0_00_0_0_0_0_0;
  localparam obs_t DEC_ILL = 11'b001_0_00_0_0_0_0_1;
  localparam obs_t EX      = 11'b010_0_00_0_0_0_0_0;
  localparam obs_t EX_BR   = 11'b010_1_01_0_0_0_0_0;
  localparam obs_t EX_JAL  = 11'b010_1_10_0_0_0_0_0;
  localparam obs_t MEM_RD  = 11'b011_0_00_0_1_0_0_0;
  localparam obs_t MEM_WR  = 11'b011_0_00_0_0_1_0_0;
  localparam obs_t WB      = 11'b100_0_00_0_0_0_1_0;
  localparam obs_t RST_F   = 11'b000_0_00_0_0_0_0_0;
  localparam obs_t RST_DEC = 11'b001_0_00_0_0_0_0_0;
  localparam obs_t RST_MEM = 11'b011_0_00_0_0_0_0_0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

`ifdef MEM_WAIT_EN
  localparam logic MR = 1'b1;
`else
  localparam logic MR = 1'b0;
`endif

  typedef struct {
    logic [6:0]           op;
    logic [6:0]           alt;
    logic                 bc;
    int                   n;
    logic [0:4][10:0]     exp;
    logic                 ret;
    string                name;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_ir = 16'd0;
  obs_t        exp_q[$];
  vec_t        tbl[10];

  function automatic vec_t mk(input logic [6:0] op, input logic [6:0] alt, input logic bc,
                              input int n, input obs_t e0, input obs_t e1, input obs_t e2,
                              input obs_t e3, input obs_t e4, input logic ret, input string nm);
    vec_t v;
    v.op = op; v.alt = alt; v.bc = bc; v.n = n; v.ret = ret; v.name = nm;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  // One clock cycle: drive just after the rising edge, compare on the falling edge.
  task automatic step(input logic [6:0] op, input logic bc, input logic mr, input logic rst,
                      input obs_t e, input string nm, input bit chk_ir, input logic [15:0] ir_exp);
    obs_t got, want;
    @(posedge clk);
    #1;
    opcode = op; branch_cond = bc; mem_ready = mr; reset = rst;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    got  = {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, illegal};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: outputs got %b required %b", nm, got, want);
    end
    if (chk_ir) begin
      n_vec++;
      if (instret !== ir_exp) begin
        n_err++;
        $display("FAIL %s instret: got %h required %h", nm, instret, ir_exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; branch_cond = 1'b0; mem_ready = 1'b0;

    tbl[0] = mk(OP_R,  OP_LD,  1'b1, 4, F_DONE, DEC, EX,     WB,     '0, 1'b1, "rtype");
    tbl[1] = mk(OP_I,  OP_ST,  1'b1, 4, F_DONE, DEC, EX,     WB,     '0, 1'b1, "itype");
    tbl[2] = mk(OP_LD, OP_R,   1'b1, 5, F_DONE, DEC, EX,     MEM_RD, WB, 1'b1, "load");
    tbl[3] = mk(OP_ST, OP_LD,  1'b1, 4, F_DONE, DEC, EX,     MEM_WR, '0, 1'b1, "store");
    tbl[4] = mk(OP_BR, OP_JAL, 1'b1, 3, F_DONE, DEC, EX_BR,  '0,     '0, 1'b1, "br_taken");
    tbl[5] = mk(OP_BR, OP_JAL, 1'b0, 3, F_DONE, DEC, EX,     '0,     '0, 1'b1, "br_not");
    tbl[6] = mk(OP_JAL, OP_BR, 1'b1, 4, F_DONE, DEC, EX_JAL, WB,     '0, 1'b1, "jal");
    tbl[7] = mk(7'h7F, OP_R,   1'b1, 2, F_DONE, DEC_ILL, '0, '0,     '0, 1'b0, "ill_7f");
    tbl[8] = mk(7'h00, OP_LD,  1'b1, 2, F_DONE, DEC_ILL, '0, '0,     '0, 1'b0, "ill_00");
    tbl[9] = mk(7'h37, OP_JAL, 1'b1, 2, F_DONE, DEC_ILL, '0, '0,     '0, 1'b0, "ill_lui");

    step(7'd0, 1'b0, 1'b0, 1'b1, RST_F, "reset0", 1'b0, 16'd0);
    step(7'd0, 1'b0, 1'b0, 1'b1, RST_F, "reset1", 1'b1, 16'd0);

    // Every instruction runs twice so retirement counting accumulates.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        for (int k = 0; k < tbl[i].n; k++) begin
          step((k < 2) ? tbl[i].op : tbl[i].alt, tbl[i].bc, MR, 1'b0, tbl[i].exp[k],
               $sformatf("%s[%0d]", tbl[i].name, k), (k == 0), exp_ir);
        end
        exp_ir = exp_ir + {15'd0, tbl[i].ret};
      end
    end

    // Reset during MEM of a STORE aborts it without retiring.
    step(OP_ST, 1'b0, MR, 1'b0, F_DONE,  "rst_st_f",   1'b1, exp_ir);
    step(OP_ST, 1'b0, MR, 1'b0, DEC,     "rst_st_d",   1'b0, 16'd0);
    step(OP_ST, 1'b0, MR, 1'b0, EX,      "rst_st_e",   1'b0, 16'd0);
    step(OP_ST, 1'b0, MR, 1'b1, RST_MEM, "rst_st_mem", 1'b0, 16'd0);
    exp_ir = 16'd0;
    step(OP_R,  1'b0, MR, 1'b0, F_DONE,  "rst_st_post", 1'b1, exp_ir);
    step(OP_R,  1'b0, MR, 1'b0, DEC,     "post_r_d",   1'b0, 16'd0);
    step(OP_R,  1'b0, MR, 1'b0, EX,      "post_r_e",   1'b0, 16'd0);
    step(OP_R,  1'b0, MR, 1'b0, WB,      "post_r_wb",  1'b0, 16'd0);
    exp_ir = 16'd1;

    // Reset during DECODE of an illegal opcode suppresses the illegal pulse.
    step(7'h7F, 1'b0, MR, 1'b0, F_DONE,  "rst_ill_f",  1'b1, exp_ir);
    step(7'h7F, 1'b0, MR, 1'b1, RST_DEC, "rst_ill_d",  1'b0, 16'd0);
    exp_ir = 16'd0;
    step(OP_JAL, 1'b0, MR, 1'b0, F_DONE, "jal_f",      1'b1, exp_ir);

    // Counter wrap: preload all-ones while this JAL is in flight.
    force dut.instret_q = 16'hFFFF;
    #1;
    release dut.instret_q;
    step(OP_JAL, 1'b0, MR, 1'b0, DEC,    "wrap_d",     1'b1, 16'hFFFF);
    step(OP_R,   1'b0, MR, 1'b0, EX_JAL, "wrap_e",     1'b1, 16'hFFFF);
    step(OP_R,   1'b0, MR, 1'b0, WB,     "wrap_wb",    1'b1, 16'hFFFF);
    step(OP_BR,  1'b1, MR, 1'b0, F_DONE, "wrap_f",     1'b1, 16'h0000);
    step(OP_BR,  1'b1, MR, 1'b0, DEC,    "wrap_br_d",  1'b0, 16'd0);
    step(OP_ST,  1'b1, MR, 1'b0, EX_BR,  "wrap_br_e",  1'b0, 16'd0);
    step(OP_R,   1'b0, MR, 1'b0, F_DONE, "after_wrap", 1'b1, 16'h0001);

`ifdef MEM_WAIT_EN
    // LOAD with mem_ready low three cycles in both FETCH and MEM.
    step(OP_R, 1'b0, 1'b0, 1'b0, DEC, "mw_pad_d", 1'b0, 16'd0);
    step(OP_R, 1'b0, 1'b0, 1'b0, EX,  "mw_pad_e", 1'b0, 16'd0);
    step(OP_R, 1'b0, 1'b0, 1'b0, WB,  "mw_pad_wb", 1'b0, 16'd0);
    for (int k = 0; k < 3; k++) step(OP_LD, 1'b0, 1'b0, 1'b0, F_WAIT, $sformatf("mw_fwait%0d", k), 1'b1, 16'h0002);
    step(OP_LD, 1'b0, 1'b1, 1'b0, F_DONE, "mw_fdone", 1'b0, 16'd0);
    step(OP_LD, 1'b0, 1'b0, 1'b0, DEC,    "mw_d",     1'b0, 16'd0);
    step(OP_ST, 1'b0, 1'b0, 1'b0, EX,     "mw_e",     1'b0, 16'd0);
    for (int k = 0; k < 3; k++) step(OP_ST, 1'b0, 1'b0, 1'b0, MEM_RD, $sformatf("mw_mwait%0d", k), 1'b0, 16'd0);
    step(OP_ST, 1'b0, 1'b1, 1'b0, MEM_RD, "mw_mdone", 1'b0, 16'd0);
    step(OP_ST, 1'b0, 1'b0, 1'b0, WB,     "mw_wb",    1'b0, 16'd0);
    step(OP_R,  1'b0, 1'b0, 1'b0, F_WAIT, "mw_next",  1'b1, 16'h0003);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: opcode  input  7  instruction opcode field from instruction register.
REQ-004 SHALL have port: branch_cond  input  1  branch condition from ALU, valid in EXEC.
REQ-005 SHALL have port: mem_ready  input  1  memory access complete.
REQ-006 SHALL have port: PCWrite  output  1  pc register load enable.
REQ-007 SHALL have port: PCSrc  output  2  PCNext select: 00 PC+4, 01 branch target, 10 jump target, 11 unused.
REQ-008 SHALL have ports: IRWrite, MemRead, MemWrite, RegWrite  output  1 each  datapath strobes.
REQ-009 SHALL have port: state  output  3  current FSM state, debug.
REQ-010 SHALL have port: illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-011 SHALL have port: instret  output  16  retired-instruction counter.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL transition to FETCH.
REQ-013 In FETCH, SHALL assert MemRead; on fetch completion, SHALL assert IRWrite, PCWrite and PCSrc=00 for exactly that cycle, then go to DECODE.
REQ-014 DECODE SHALL last one cycle, no strobes; opcode 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 go to EXEC; any other opcode pulses illegal and goes to FETCH without incrementing instret.
REQ-015 EXEC, R/I-type (0110011, 0010011): go to WB.
REQ-016 EXEC, LOAD/STORE: go to MEM.
REQ-017 EXEC, BRANCH: PCSrc=01, PCWrite=branch_cond, go to FETCH, instruction retires.
REQ-018 EXEC, JAL: PCSrc=10, PCWrite=1, go to WB (link write).
REQ-019 MEM: LOAD asserts MemRead, STORE asserts MemWrite; on completion LOAD goes to WB, STORE goes to FETCH and retires.
REQ-020 WB: RegWrite=1 for one cycle, go to FETCH, instruction retires.
REQ-021 PCWrite SHALL never be asserted outside FETCH completion or EXEC of BRANCH/JAL; at most one PCWrite per instruction beyond fetch.
REQ-022 PCSrc SHALL be 00 whenever PCWrite=0.
REQ-023 Strobes SHALL be combinational from state and registered opcode; state and instret registered.
REQ-024 instret SHALL increment by 1 on the cycle leaving the retiring state; wraps 0xFFFF to 0x0000.
REQ-025 opcode SHALL be latched internally on DECODE; changes to opcode input after DECODE SHALL not alter the instruction's path.

Reset
REQ-026 reset SHALL override all transitions: next state FETCH, instret=0, latched opcode=0.
REQ-027 While reset is high, PCWrite, IRWrite, MemWrite, RegWrite, illegal SHALL be 0.
REQ-028 Reset mid-instruction SHALL abort with no retirement count and no further strobes.

Configuration
REQ-029 Macro MEM_WAIT_EN: defined, FETCH and MEM hold (strobes held, no PCWrite/IRWrite) until mem_ready=1, completion on the mem_ready cycle.
REQ-030 Without MEM_WAIT_EN, FETCH and MEM complete in one cycle and mem_ready is ignored.

Verification
REQ-031 R-type 0110011, mem_ready=1: states 0,1,2,4,0; PCWrite only in FETCH with PCSrc=00; RegWrite in WB; instret 0->1.
REQ-032 BRANCH 1100011 with branch_cond=1, then 0: first EXEC PCWrite=1 PCSrc=01; second PCWrite=0 PCSrc=00; instret +2.
REQ-033 MEM_WAIT_EN, LOAD 0000011, mem_ready low 3 cycles in FETCH and MEM: each state held 4 cycles, PCWrite single cycle, RegWrite in WB.
REQ-034 Opcode 1111111: illegal pulses in DECODE, back to FETCH, instret unchanged.
REQ-035 reset asserted during MEM of STORE: next cycle state=0, MemWrite=0, instret=0.
REQ-036 Preload instret=0xFFFF via 65535 retirements of JAL: next retirement yields 0x0000.
